// File: rtl/tdm_demux8.sv
// Receive side of the 8-slot TDM link: collects framed serial slots into a shadow
// register and publishes each complete frame on D0..D7 with a one-cycle strobe.
module tdm_demux8 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] D0,
    output logic [WIDTH-1:0] D1,
    output logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] D3,
    output logic [WIDTH-1:0] D4,
    output logic [WIDTH-1:0] D5,
    output logic [WIDTH-1:0] D6,
    output logic [WIDTH-1:0] D7,
    output logic             frame_valid,
    output logic             frame_err,
    output logic [2:0]       S
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state;
    // Slot 7 goes straight from din to D7, so only slots 0..6 need holding.
    logic [WIDTH-1:0] shadow [0:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            S           <= 3'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            D0 <= '0; D1 <= '0; D2 <= '0; D3 <= '0;
            D4 <= '0; D5 <= '0; D6 <= '0; D7 <= '0;
            // NOTE: the shadow is small enough to live in flops, so it is reset with
            // everything else; a RAM-backed store would not be reset this way.
            for (int i = 0; i < 7; i++) shadow[i] <= '0;
        end else begin
            // NOTE: pulses default low every cycle and are overridden below; with
            // non-blocking assignments the last write in the block wins.
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (din_valid) begin
                case (state)
                    IDLE: begin
                        if (frame_start) begin
                            shadow[0] <= din;
                            S         <= 3'd1;
                            state     <= COLLECT;
                        end
                    end

                    COLLECT: begin
                        if (frame_start) begin
                            // Early start drops the partial frame and resyncs on this beat.
                            if (S != 3'd0) frame_err <= 1'b1;
                            shadow[0] <= din;
                            S         <= 3'd1;
                        end else if (S == 3'd0) begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end else if (S == 3'd7) begin
                            D0 <= shadow[0];
                            D1 <= shadow[1];
                            D2 <= shadow[2];
                            D3 <= shadow[3];
                            D4 <= shadow[4];
                            D5 <= shadow[5];
                            D6 <= shadow[6];
                            D7 <= din;
                            frame_valid <= 1'b1;
                            S           <= 3'd0;
                        end else begin
                            shadow[S] <= din;
                            S         <= S + 3'd1;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a table of beats with hand-derived expected
// outputs, followed by hand-written reset sequences.
module tb_tdm_demux8;

    localparam int W = 8;

    typedef struct {
        logic        v;
        logic        fs;
        logic [7:0]  din;
        logic        fv;
        logic        err;
        logic [2:0]  s;
        logic [63:0] d;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_start;
    logic [W-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
    logic         frame_valid;
    logic         frame_err;
    logic [2:0]   S;
    logic [63:0]  dout;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    logic [63:0] cur_d;

    tdm_demux8 #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start),
        .D0(D0), .D1(D1), .D2(D2), .D3(D3), .D4(D4), .D5(D5), .D6(D6), .D7(D7),
        .frame_valid(frame_valid), .frame_err(frame_err), .S(S)
    );

    assign dout = {D7, D6, D5, D4, D3, D2, D1, D0};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected D word {D7..D0} for a frame whose slot n carries base+n.
    function automatic logic [63:0] frm(input logic [7:0] base);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(base + 8'(i));
        return r;
    endfunction

    task automatic add(input logic v, input logic fs, input logic [7:0] d,
                       input logic fv, input logic err, input logic [2:0] s);
        vec_t x;
        x.v = v; x.fs = fs; x.din = d; x.fv = fv; x.err = err; x.s = s; x.d = cur_d;
        vecs.push_back(x);
    endtask

    // Plain frame base..base+7 on consecutive valid beats.
    task automatic add_frame(input logic [7:0] base);
        for (int k = 0; k < 8; k++) begin
            if (k == 7) cur_d = frm(base);
            add(1'b1, k == 0, 8'(base + 8'(k)), k == 7, 1'b0, 3'((k + 1) % 8));
        end
    endtask

    task automatic beat(input logic v, input logic fs, input logic [7:0] d);
        @(negedge clk);
        din_valid = v; frame_start = fs; din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic fv, input logic err,
                             input logic [2:0] s, input logic [63:0] d);
        check({tag, " frame_valid"}, 64'(frame_valid), 64'(fv));
        check({tag, " frame_err"},   64'(frame_err),   64'(err));
        check({tag, " S"},           64'(S),           64'(s));
        check({tag, " D"},           dout,             d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; frame_start = 1'b0;

        cur_d = 64'd0;
        // Reset, then frame 0..7.
        add_frame(8'h00);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        // Back-to-back frames with din_valid held high.
        add_frame(8'hA0);
        add_frame(8'hB0);
        // Gaps of three idle cycles after slots 2 and 5; frame_start/din must be ignored.
        for (int k = 0; k < 8; k++) begin
            if (k == 7) cur_d = frm(8'hC0);
            add(1'b1, k == 0, 8'(8'hC0 + 8'(k)), k == 7, 1'b0, 3'((k + 1) % 8));
            if (k == 2 || k == 5)
                for (int g = 0; g < 3; g++) add(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 3'(k + 1));
        end
        // Early frame_start at slot 4: error, resync beat becomes D0.
        for (int k = 0; k < 4; k++) add(1'b1, k == 0, 8'(8'hE0 + 8'(k)), 1'b0, 1'b0, 3'(k + 1));
        add(1'b1, 1'b1, 8'hF0, 1'b0, 1'b1, 3'd1);
        for (int k = 1; k < 8; k++) begin
            if (k == 7) cur_d = frm(8'hF0);
            add(1'b1, 1'b0, 8'(8'hF0 + 8'(k)), k == 7, 1'b0, 3'((k + 1) % 8));
        end
        // Missing start after a good frame: one error, then silent IDLE until frame_start.
        add(1'b1, 1'b0, 8'h55, 1'b0, 1'b1, 3'd0);
        add(1'b1, 1'b0, 8'h56, 1'b0, 1'b0, 3'd0);
        add(1'b1, 1'b0, 8'h57, 1'b0, 1'b0, 3'd0);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);
        add_frame(8'h10);
        add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 3'd0);

        // Reset state.
        #2;
        check_all("reset", 1'b0, 1'b0, 3'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            beat(vecs[i].v, vecs[i].fs, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i].fv, vecs[i].err, vecs[i].s, vecs[i].d);
        end

        // Asynchronous reset after slot 5 of a frame.
        for (int k = 0; k < 6; k++) beat(1'b1, k == 0, 8'(8'h20 + 8'(k)));
        check_all("pre_rst", 1'b0, 1'b0, 3'd6, frm(8'h10));
        @(negedge clk);
        din_valid = 1'b0; frame_start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all("mid_rst", 1'b0, 1'b0, 3'd0, 64'd0);
        @(posedge clk);
        #1;
        check_all("held_rst", 1'b0, 1'b0, 3'd0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // Slot beats without frame_start after reset are ignored, then a full frame.
        beat(1'b1, 1'b0, 8'h26);
        check_all("post_rst_idle", 1'b0, 1'b0, 3'd0, 64'd0);
        for (int k = 0; k < 8; k++) begin
            beat(1'b1, k == 0, 8'(8'h30 + 8'(k)));
            if (k < 7) check_all($sformatf("rf%0d", k), 1'b0, 1'b0, 3'(k + 1), 64'd0);
            else       check_all("rf7", 1'b1, 1'b0, 3'd0, frm(8'h30));
        end
        beat(1'b0, 1'b0, 8'h00);
        check_all("rf_end", 1'b0, 1'b0, 3'd0, frm(8'h30));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
